// File: rtl/pw_gated_reg_bank.sv
// Password-gated register bank with failure lockout; writes need a grant registered on an earlier cycle.
// Optional idle auto-relock is enabled by defining PW_GATED_REG_AUTO_RELOCK_EN.
module pw_gated_reg_bank #(
   parameter int              DATA_W         = 8,
   parameter int              PW_W           = 3,
   parameter int              NUM_REGS       = 4,
   parameter logic [PW_W-1:0] PASSWORD       = 3'h4,
   parameter int              MAX_ATTEMPTS   = 3,
   parameter int              LOCKOUT_CYCLES = 16,
   parameter int              IDLE_CYCLES    = 64,
   localparam int             ADDR_W         = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pw_valid,
   input  logic [PW_W-1:0]   pw_in,
   input  logic              relock,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              unlocked,
   output logic              locked_out,
   output logic              wr_err
);

   localparam int FW = $clog2(MAX_ATTEMPTS + 1);
   localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_ATTEMPTS - 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);

   if (NUM_REGS < 2 || PASSWORD == '0 || MAX_ATTEMPTS < 1 ||
       LOCKOUT_CYCLES < 1 || IDLE_CYCLES < 1) begin : g_bad_params
      $error("pw_gated_reg_bank: invalid parameter set");
   end

   typedef enum logic [1:0] {LOCKED, UNLOCKED, LOCKOUT} state_t;

   state_t            state, state_next;
   logic [FW-1:0]     fail_cnt;
   logic [TW-1:0]     timer;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              pw_ok, wr_ok, rd_in_range;

`ifdef PW_GATED_REG_AUTO_RELOCK_EN
   localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
   logic [IW-1:0] idle_cnt;
`endif

   // A write needs the grant already in state; relock in the same cycle takes priority.
   assign pw_ok       = (pw_in == PASSWORD) && (pw_in != '0);
   assign wr_ok       = wr_en && (state == UNLOCKED) && !relock && (32'(wr_addr) < NUM_REGS);
   assign rd_in_range = 32'(rd_addr) < NUM_REGS;

   always_comb begin
      state_next = state;
      case (state)
         LOCKED: begin
            if (pw_valid) begin
               if (pw_ok)                       state_next = UNLOCKED;
               else if (fail_cnt == FAIL_LAST)  state_next = LOCKOUT;
            end
         end
         UNLOCKED: begin
            if (relock) state_next = LOCKED;
`ifdef PW_GATED_REG_AUTO_RELOCK_EN
            else if (!wr_ok && idle_cnt == IDLE_LAST) state_next = LOCKED;
`endif
         end
         LOCKOUT: begin
            if (timer == '0) state_next = LOCKED;
         end
         default: state_next = LOCKED;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= LOCKED;
         fail_cnt   <= '0;
         timer      <= '0;
         rd_data    <= '0;
         unlocked   <= 1'b0;
         locked_out <= 1'b0;
         wr_err     <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef PW_GATED_REG_AUTO_RELOCK_EN
         idle_cnt   <= '0;
`endif
      end else begin
         state      <= state_next;
         unlocked   <= (state_next == UNLOCKED);
         locked_out <= (state_next == LOCKOUT);
         wr_err     <= wr_en && !wr_ok;
         // Gate on the next state so contents vanish on the same edge the session ends.
         rd_data    <= (state_next == UNLOCKED && rd_in_range) ? regs[rd_addr] : '0;
         if (wr_ok) regs[wr_addr] <= wr_data;

         case (state)
            LOCKED: begin
               if (pw_valid) begin
                  if (pw_ok) begin
                     fail_cnt <= '0;
                  end else if (fail_cnt == FAIL_LAST) begin
                     fail_cnt <= '0;
                     timer    <= TIMER_LOAD;
                  end else begin
                     fail_cnt <= fail_cnt + 1'b1;
                  end
               end
            end
            LOCKOUT: begin
               if (timer != '0) timer <= timer - 1'b1;
            end
            default: ;
         endcase

`ifdef PW_GATED_REG_AUTO_RELOCK_EN
         idle_cnt <= (state == UNLOCKED && state_next == UNLOCKED && !wr_ok) ?
                     idle_cnt + 1'b1 : '0;
`endif
      end
   end

endmodule
